fetch_priv_seq: RTL and testbench
=================================

FETCH_PRIV_SEQ -- requirements
Module: fetch_priv_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 10, width of the watchdog counter (used only with PRIV_SEQ_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  in  1  synchronous pipeline flush.
REQ-005 SHALL have port fetch_valid  in  1  an IF1 bundle is pushed into the fetch FIFO this cycle.
REQ-006 SHALL have port fetch_pc  in  32  PC of the pushed bundle.
REQ-007 SHALL have ports ibar_flag, csr_flag, tlb_flag  in  2 each  pre-decode flags; bit0 is slot0 and bit1 is slot1.
REQ-008 SHALL have ports ibar_ex, csr_ex, tlb_ex  in  1 each  the flagged instruction has reached EX.
REQ-009 SHALL have ports icache_idle, dcache_idle, csr_done, tlb_done  in  1 each  completion indications.
REQ-010 SHALL have port fetch_hold  out  1  blocks IF1 acceptance.
REQ-011 SHALL have port flush_fetch  out  1  clears the IF0/IF1 stage registers.
REQ-012 SHALL have ports set_pc  out  1 and pc_out  out  32  one-cycle redirect request and its target.
REQ-013 SHALL have ports busy  out  1 (state != IDLE) and timeout_err  out  1.

Function
REQ-014 SHALL implement the states IDLE, WAIT_EX_IBAR, WAIT_EX_CSR, WAIT_EX_TLB, WAIT_CACHE, WAIT_CSR, WAIT_TLB and REDIRECT, with all outputs decoded from the registered state (Moore).
REQ-015 Detection: in IDLE with fetch_valid=1, if any flag bit is set, SHALL select the lowest flagged slot; slot0 wins over slot1.
REQ-016 Within the selected slot, type priority SHALL be ibar > csr > tlb.
REQ-017 On detection SHALL capture target = fetch_pc+4 (slot0) or fetch_pc+8 (slot1), using 32-bit wrap-around arithmetic.
REQ-018 On detection SHALL move next cycle to WAIT_EX_IBAR, WAIT_EX_CSR or WAIT_EX_TLB per the selected type; with no flags set or fetch_valid=0, SHALL stay in IDLE.
REQ-019 SHALL ignore fetch_valid and all flags outside IDLE.
REQ-020 WAIT_EX_IBAR: SHALL go to WAIT_CACHE on ibar_ex; if icache_idle && dcache_idle is also true that cycle, SHALL go directly to REDIRECT.
REQ-021 WAIT_EX_CSR: on csr_ex, SHALL go to REDIRECT if csr_done is high that cycle, otherwise to WAIT_CSR.
REQ-022 WAIT_EX_TLB: on tlb_ex, SHALL go to REDIRECT if tlb_done is high that cycle, otherwise to WAIT_TLB.
REQ-023 SHALL ignore csr_done and tlb_done before the matching *_ex; they SHALL NOT be remembered.
REQ-024 WAIT_CACHE SHALL go to REDIRECT when icache_idle && dcache_idle; WAIT_CSR on csr_done; WAIT_TLB on tlb_done.
REQ-025 REDIRECT SHALL assert set_pc=1 with pc_out=target for exactly one cycle, then go to IDLE; a completion seen in cycle N SHALL give set_pc in cycle N+1.
REQ-026 fetch_hold SHALL be 1 in every non-IDLE state.
REQ-027 flush_fetch SHALL be 1 in the WAIT_EX_* states only.
REQ-028 pc_out SHALL hold the last target while set_pc=0.
REQ-029 flush SHALL force IDLE next cycle from any state, including REDIRECT, with no set_pc.
REQ-030 flush SHALL clear target and the counter, and SHALL win over a simultaneous detection.

Reset
REQ-031 rstn low SHALL immediately force state=IDLE, target=0, pc_out=0, counter=0, and fetch_hold, flush_fetch, set_pc, busy and timeout_err all 0.
REQ-032 Reset mid-sequence SHALL abandon the sequence with no set_pc after release.

Configuration
REQ-033 With macro PRIV_SEQ_TIMEOUT_EN defined, a TIMEOUT_W-bit counter SHALL count cycles in the WAIT_* states and clear on entering IDLE.
REQ-034 With PRIV_SEQ_TIMEOUT_EN defined, when the counter reaches all-ones the FSM SHALL enter REDIRECT next cycle and assert timeout_err together with set_pc for that one cycle.
REQ-035 Without PRIV_SEQ_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be tied to 0, and wait states SHALL wait indefinitely.

Verification
REQ-036 ibar: fetch_pc=0x1C000000, ibar_flag=01; ibar_ex 3 cycles later; caches idle 5 cycles after that -> flush_fetch high in WAIT_EX only, then one set_pc with pc_out=0x1C000004.
REQ-037 csr: fetch_pc=0x1C000010, csr_flag=10 -> target 0x1C000018; csr_ex and csr_done in the same cycle -> set_pc on the next cycle.
REQ-038 Priority: ibar_flag=10 and tlb_flag=01 together -> WAIT_EX_TLB with target fetch_pc+4; fetch_pc=0xFFFFFFFC slot1 -> target 0x00000004.
REQ-039 Flush: flush asserted in WAIT_TLB and then tlb_done -> IDLE, no set_pc, busy=0; flush during the detection cycle -> stays IDLE.
REQ-040 Timeout (macro defined, TIMEOUT_W=4): wait in WAIT_CSR with csr_done=0 -> set_pc and timeout_err pulse after 15 counted wait cycles; without the macro -> still waiting after 100 cycles.
REQ-041 Async reset in WAIT_CACHE -> outputs 0 immediately; after release, caches idle -> no set_pc.

Source files
------------

// File: rtl/fetch_priv_seq.sv
// Fetch-side sequencer for privileged/serialising instructions (ibar, csr, tlb).
// Optional watchdog enabled by defining PRIV_SEQ_TIMEOUT_EN.
module fetch_priv_seq #(
  parameter int unsigned TIMEOUT_W = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic [1:0]  ibar_flag,
  input  logic [1:0]  csr_flag,
  input  logic [1:0]  tlb_flag,
  input  logic        ibar_ex,
  input  logic        csr_ex,
  input  logic        tlb_ex,
  input  logic        icache_idle,
  input  logic        dcache_idle,
  input  logic        csr_done,
  input  logic        tlb_done,
  output logic        fetch_hold,
  output logic        flush_fetch,
  output logic        set_pc,
  output logic [31:0] pc_out,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE, WAIT_EX_IBAR, WAIT_EX_CSR, WAIT_EX_TLB,
    WAIT_CACHE, WAIT_CSR, WAIT_TLB, REDIRECT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [31:0] pc_q, pc_d;
  logic        in_wait;
  logic        slot0_hit;
  logic        sel_ibar, sel_csr, sel_tlb;
  logic        caches_idle;

  assign in_wait     = (state_q != IDLE) && (state_q != REDIRECT);
  assign caches_idle = icache_idle && dcache_idle;
  assign slot0_hit   = ibar_flag[0] | csr_flag[0] | tlb_flag[0];
  assign sel_ibar    = slot0_hit ? ibar_flag[0] : ibar_flag[1];
  assign sel_csr     = slot0_hit ? csr_flag[0]  : csr_flag[1];
  assign sel_tlb     = slot0_hit ? tlb_flag[0]  : tlb_flag[1];

`ifdef PRIV_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 tmo_q, tmo_d;
  logic                 tmo_hit;

  assign cnt_inc = cnt_q + 1'b1;
  assign tmo_hit = in_wait && (cnt_inc == '1);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      target_q <= '0;
      pc_q     <= '0;
`ifdef PRIV_SEQ_TIMEOUT_EN
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      pc_q     <= pc_d;
`ifdef PRIV_SEQ_TIMEOUT_EN
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
`ifdef PRIV_SEQ_TIMEOUT_EN
    tmo_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (fetch_valid && (|{ibar_flag, csr_flag, tlb_flag})) begin
          target_d = fetch_pc + (slot0_hit ? 32'd4 : 32'd8);
          if (sel_ibar)      state_d = WAIT_EX_IBAR;
          else if (sel_csr)  state_d = WAIT_EX_CSR;
          else if (sel_tlb)  state_d = WAIT_EX_TLB;
        end
      end
      WAIT_EX_IBAR: if (ibar_ex) state_d = caches_idle ? REDIRECT : WAIT_CACHE;
      WAIT_EX_CSR:  if (csr_ex)  state_d = csr_done ? REDIRECT : WAIT_CSR;
      WAIT_EX_TLB:  if (tlb_ex)  state_d = tlb_done ? REDIRECT : WAIT_TLB;
      WAIT_CACHE:   if (caches_idle) state_d = REDIRECT;
      WAIT_CSR:     if (csr_done)    state_d = REDIRECT;
      WAIT_TLB:     if (tlb_done)    state_d = REDIRECT;
      REDIRECT:     state_d = IDLE;
      default:      state_d = IDLE;
    endcase
`ifdef PRIV_SEQ_TIMEOUT_EN
    // A genuine completion on the expiry cycle is not reported as a timeout.
    if (tmo_hit && (state_d != REDIRECT)) begin
      state_d = REDIRECT;
      tmo_d   = 1'b1;
    end
`endif
    if (flush) begin
      state_d  = IDLE;
      target_d = '0;
`ifdef PRIV_SEQ_TIMEOUT_EN
      tmo_d    = 1'b0;
`endif
    end
  end

  // pc_out only moves when a redirect is issued, so it holds between redirects.
  always_comb begin
    pc_d = pc_q;
    if ((state_d == REDIRECT) && (state_q != REDIRECT)) pc_d = target_q;
  end

`ifdef PRIV_SEQ_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == IDLE) cnt_d = '0;
    else if (in_wait)    cnt_d = cnt_inc;
  end
`endif

  always_comb begin
    fetch_hold  = (state_q != IDLE);
    busy        = (state_q != IDLE);
    flush_fetch = (state_q == WAIT_EX_IBAR) || (state_q == WAIT_EX_CSR) ||
                  (state_q == WAIT_EX_TLB);
    set_pc      = (state_q == REDIRECT);
    pc_out      = pc_q;
`ifdef PRIV_SEQ_TIMEOUT_EN
    timeout_err = (state_q == REDIRECT) && tmo_q;
`else
    timeout_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_fetch_priv_seq.sv
// Self-checking bench for fetch_priv_seq: detection vector table plus directed
// multi-cycle sequences; redirect targets go through a scoreboard queue.
module tb_fetch_priv_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush, fetch_valid;
  logic [31:0] fetch_pc;
  logic [1:0]  ibar_flag, csr_flag, tlb_flag;
  logic        ibar_ex, csr_ex, tlb_ex;
  logic        icache_idle, dcache_idle, csr_done, tlb_done;
  logic        fetch_hold, flush_fetch, set_pc, busy, timeout_err;
  logic [31:0] pc_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  fetch_priv_seq #(.TIMEOUT_W(4)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .ibar_flag(ibar_flag), .csr_flag(csr_flag),
    .tlb_flag(tlb_flag), .ibar_ex(ibar_ex), .csr_ex(csr_ex), .tlb_ex(tlb_ex),
    .icache_idle(icache_idle), .dcache_idle(dcache_idle), .csr_done(csr_done),
    .tlb_done(tlb_done), .fetch_hold(fetch_hold), .flush_fetch(flush_fetch),
    .set_pc(set_pc), .pc_out(pc_out), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [1:0]  ib, cs, tl;
    int unsigned kind;   // 0 none, 1 ibar, 2 csr, 3 tlb
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; fetch_valid = 0; fetch_pc = '0;
    ibar_flag = '0; csr_flag = '0; tlb_flag = '0;
    ibar_ex = 0; csr_ex = 0; tlb_ex = 0;
    icache_idle = 0; dcache_idle = 0; csr_done = 0; tlb_done = 0;
  endtask

  task automatic detect(input logic [31:0] pc, input logic [1:0] ib,
                        input logic [1:0] cs, input logic [1:0] tl);
    fetch_valid = 1; fetch_pc = pc; ibar_flag = ib; csr_flag = cs; tlb_flag = tl;
    step();
    fetch_valid = 0; fetch_pc = '0; ibar_flag = '0; csr_flag = '0; tlb_flag = '0;
  endtask

  // Called on the cycle a redirect is expected: pops the scoreboard.
  task automatic expect_redirect(input string nm);
    chk({nm, " set_pc"}, {31'd0, set_pc}, 32'd1);
    if (set_pc) begin
      if (sb_q.size() == 0) begin
        chk({nm, " sb_nonempty"}, 32'd0, 32'd1);
      end else begin
        chk({nm, " pc_out"}, pc_out, sb_q.pop_front());
      end
    end
  endtask

  task automatic recover();
    if (busy) begin
      flush = 1; step(); flush = 0;
    end
    sb_q.delete();
  endtask

  initial begin
    int waits;
    int seen;
    clear_inputs();
    rstn = 0;

    vecs[0]  = '{1'b1, 32'h1C000000, 2'b01, 2'b00, 2'b00, 1, 32'h1C000004};
    vecs[1]  = '{1'b1, 32'h1C000010, 2'b00, 2'b10, 2'b00, 2, 32'h1C000018};
    vecs[2]  = '{1'b1, 32'h00002000, 2'b10, 2'b00, 2'b01, 3, 32'h00002004};
    vecs[3]  = '{1'b1, 32'hFFFFFFFC, 2'b00, 2'b00, 2'b10, 3, 32'h00000004};
    vecs[4]  = '{1'b1, 32'h00000100, 2'b01, 2'b01, 2'b01, 1, 32'h00000104};
    vecs[5]  = '{1'b1, 32'h00000200, 2'b00, 2'b01, 2'b01, 2, 32'h00000204};
    vecs[6]  = '{1'b1, 32'h00000300, 2'b10, 2'b10, 2'b00, 1, 32'h00000308};
    vecs[7]  = '{1'b1, 32'h00000400, 2'b00, 2'b10, 2'b10, 2, 32'h00000408};
    vecs[8]  = '{1'b1, 32'h00000500, 2'b00, 2'b00, 2'b00, 0, 32'h0};
    vecs[9]  = '{1'b1, 32'hFFFFFFF8, 2'b10, 2'b00, 2'b00, 1, 32'h00000000};
    vecs[10] = '{1'b0, 32'h00000600, 2'b01, 2'b01, 2'b01, 0, 32'h0};

    #3;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset set_pc", {31'd0, set_pc}, 32'd0);
    chk("reset pc_out", pc_out, 32'd0);
    chk("reset outs", {28'd0, fetch_hold, flush_fetch, timeout_err, set_pc}, 32'd0);
    step(); step();
    rstn = 1;
    step();

    // Table: detection, then completion in the same cycle as the matching EX.
    foreach (vecs[i]) begin
      fetch_valid = vecs[i].valid; fetch_pc = vecs[i].pc;
      ibar_flag = vecs[i].ib; csr_flag = vecs[i].cs; tlb_flag = vecs[i].tl;
      step();
      fetch_valid = 0; ibar_flag = '0; csr_flag = '0; tlb_flag = '0;
      if (vecs[i].kind == 0) begin
        chk($sformatf("vec%0d idle", i), {31'd0, busy}, 32'd0);
      end else begin
        sb_q.push_back(vecs[i].tgt);
        chk($sformatf("vec%0d flush_fetch", i), {31'd0, flush_fetch}, 32'd1);
        case (vecs[i].kind)
          1: begin ibar_ex = 1; icache_idle = 1; dcache_idle = 1; end
          2: begin csr_ex = 1; csr_done = 1; end
          default: begin tlb_ex = 1; tlb_done = 1; end
        endcase
        step();
        clear_inputs();
        expect_redirect($sformatf("vec%0d", i));
        step();
        chk($sformatf("vec%0d after", i), {30'd0, busy, set_pc}, 32'd0);
      end
      recover();
    end

    // ibar: EX three cycles after detection, caches idle five cycles later.
    detect(32'h1C000000, 2'b01, 2'b00, 2'b00);
    sb_q.push_back(32'h1C000004);
    for (int k = 0; k < 2; k++) begin
      chk("ibar wait_ex ff", {31'd0, flush_fetch}, 32'd1);
      fetch_valid = 1; fetch_pc = 32'hDEAD0000; csr_flag = 2'b01;
      step();
      fetch_valid = 0; fetch_pc = '0; csr_flag = '0;
    end
    chk("ibar wait_ex ff3", {31'd0, flush_fetch}, 32'd1);
    ibar_ex = 1; step(); ibar_ex = 0;
    for (int k = 0; k < 4; k++) begin
      chk("ibar wait_cache", {29'd0, busy, flush_fetch, set_pc}, 32'h4);
      icache_idle = (k == 2);
      step();
    end
    icache_idle = 1; dcache_idle = 1; step(); clear_inputs();
    expect_redirect("ibar seq");
    chk("ibar timeout_err", {31'd0, timeout_err}, 32'd0);
    step();
    chk("ibar pc_out hold", pc_out, 32'h1C000004);
    chk("ibar one pulse", {31'd0, set_pc}, 32'd0);
    recover();

    // csr_done before csr_ex is not remembered; wrong-type EX is ignored.
    detect(32'h00000600, 2'b00, 2'b01, 2'b00);
    sb_q.push_back(32'h00000604);
    csr_done = 1; tlb_ex = 1; step(); csr_done = 0; tlb_ex = 0;
    chk("csr early done", {31'd0, flush_fetch}, 32'd1);
    csr_ex = 1; step(); csr_ex = 0;
    chk("csr wait_csr", {29'd0, busy, flush_fetch, set_pc}, 32'h4);
    csr_done = 1; step(); csr_done = 0;
    expect_redirect("csr seq");
    recover();

    // Flush in WAIT_TLB, then tlb_done.
    detect(32'h00000700, 2'b00, 2'b00, 2'b01);
    tlb_ex = 1; step(); tlb_ex = 0;
    flush = 1; step(); flush = 0;
    chk("flush wait_tlb busy", {31'd0, busy}, 32'd0);
    tlb_done = 1; step(); tlb_done = 0;
    chk("flush then done", {30'd0, busy, set_pc}, 32'd0);
    recover();

    // Flush wins over detection.
    flush = 1; detect(32'h00000800, 2'b01, 2'b00, 2'b00); flush = 0;
    chk("flush on detect", {31'd0, busy}, 32'd0);
    recover();

    // Flush on the completion cycle suppresses the redirect.
    detect(32'h00000900, 2'b00, 2'b01, 2'b00);
    csr_ex = 1; csr_done = 1; flush = 1; step(); clear_inputs();
    chk("flush on complete", {30'd0, busy, set_pc}, 32'd0);
    recover();

    // Watchdog.
    detect(32'h00000A00, 2'b00, 2'b10, 2'b00);
    csr_ex = 1;
`ifdef PRIV_SEQ_TIMEOUT_EN
    sb_q.push_back(32'h00000A08);
    waits = 0;
    while (!set_pc && waits < 40) begin
      waits++;
      step();
      csr_ex = 0;
    end
    chk("timeout wait cycles", waits, 32'd15);
    chk("timeout_err", {31'd0, timeout_err}, 32'd1);
    expect_redirect("timeout");
    step();
    chk("timeout_err pulse", {30'd0, timeout_err, busy}, 32'd0);
`else
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      csr_ex = 0;
      if (set_pc || timeout_err) seen++;
    end
    chk("no timeout redirect", seen, 32'd0);
    chk("still waiting", {31'd0, busy}, 32'd1);
`endif
    clear_inputs();
    recover();

    // Asynchronous reset in WAIT_CACHE.
    detect(32'h00000B00, 2'b01, 2'b00, 2'b00);
    ibar_ex = 1; step(); ibar_ex = 0;
    chk("pre-reset wait_cache", {31'd0, busy}, 32'd1);
    #2 rstn = 0;
    #1;
    chk("async reset outs", {27'd0, busy, fetch_hold, flush_fetch, set_pc, timeout_err}, 32'd0);
    chk("async reset pc_out", pc_out, 32'd0);
    #3 rstn = 1;
    icache_idle = 1; dcache_idle = 1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (set_pc || busy) seen++;
    end
    chk("no redirect after reset", seen, 32'd0);
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
